// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite word-organised SRAM slave: byte/half/word access, two-cycle ERROR response.
// Define AHB_WAIT_STATES_EN to insert WAIT_CYCLES wait states before each OKAY data phase completes.
module ahb_lite_sram_slave #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [3:0]        HPROT,
   input  logic [1:0]        HTRANS,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic [DATA_W-1:0] HRDATA,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [2:0]        fsm_state
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   typedef logic [ADDR_W:0] addr_ext_t;
   localparam addr_ext_t MEM_BYTES = addr_ext_t'(4 * MEM_DEPTH);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_DATA = 3'd1,
      S_WAIT = 3'd2,
      S_ERR1 = 3'd3,
      S_ERR2 = 3'd4
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] word_q;
   logic             write_q;
   logic [3:0]       be_q;

   logic             accept;
   logic             req_err;
   logic [3:0]       be_dec;

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   // Handshake: an address phase is taken only on a cycle where HSEL, HREADY and an
   // active HTRANS (NONSEQ/SEQ) are all high; its data phase completes on the first
   // later cycle with HREADYOUT=1, which is also when HWDATA is sampled.
   always_comb begin
      accept  = HSEL & HREADY & HTRANS[1];
      req_err = ({1'b0, HADDR} >= MEM_BYTES)
              | (HSIZE > 3'd2)
              | ((HSIZE == 3'd1) & HADDR[0])
              | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
      be_dec = 4'b0000;
      case (HSIZE)
         3'd0:    be_dec = 4'b0001 << HADDR[1:0];
         3'd1:    be_dec = HADDR[1] ? 4'b1100 : 4'b0011;
         3'd2:    be_dec = 4'b1111;
         default: be_dec = 4'b0000;
      endcase
   end

`ifdef AHB_WAIT_STATES_EN
   logic [3:0] wait_cnt;
   logic       unused_sig;
   assign unused_sig = ^{HBURST, HPROT, HTRANS[0]};
`else
   logic       unused_sig;
   assign unused_sig = ^{HBURST, HPROT, HTRANS[0], WAIT_LOAD};
`endif

   always_ff @(posedge HCLK) begin
      if (!HRESET) begin
         state     <= S_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         word_q    <= '0;
         write_q   <= 1'b0;
         be_q      <= 4'b0000;
`ifdef AHB_WAIT_STATES_EN
         wait_cnt  <= 4'd0;
`endif
      end else begin
         case (state)
            // Any cycle with HREADYOUT=1 may also carry the next pipelined address phase.
            S_IDLE, S_DATA, S_ERR2: begin
               if (accept) begin
                  word_q  <= HADDR[IDX_W+1:2];
                  write_q <= HWRITE;
                  be_q    <= be_dec;
                  if (req_err) begin
                     state     <= S_ERR1;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b1;
                  end else begin
`ifdef AHB_WAIT_STATES_EN
                     state     <= S_WAIT;
                     wait_cnt  <= WAIT_LOAD;
                     HREADYOUT <= 1'b0;
`else
                     state     <= S_DATA;
                     HREADYOUT <= 1'b1;
`endif
                     HRESP     <= 1'b0;
                  end
               end else begin
                  state     <= S_IDLE;
                  HREADYOUT <= 1'b1;
                  HRESP     <= 1'b0;
               end
            end
`ifdef AHB_WAIT_STATES_EN
            S_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state     <= S_DATA;
                  HREADYOUT <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
`endif
            S_ERR1: begin
               state     <= S_ERR2;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
            end
         endcase
      end
   end

   // Commit lands on the completing edge, so a pipelined read of the same word sees it.
   always_ff @(posedge HCLK) begin
      if (HRESET && (state == S_DATA) && write_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[word_q][8*i +: 8] <= HWDATA[8*i +: 8];
         end
      end
   end

   always_comb begin
      HRDATA = '0;
      if ((state == S_DATA) && !write_q) HRDATA = mem[word_q];
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: table of pipelined transfers with a response scoreboard,
// plus hand sequences for reset in the middle of a transfer.
module tb_ahb_lite_sram_slave;

   localparam int WAIT_N = 2;
`ifdef AHB_WAIT_STATES_EN
   localparam int OK_WAITS = WAIT_N;
`else
   localparam int OK_WAITS = 0;
`endif

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic [31:0] HRDATA;
   logic        HREADYOUT;
   logic        HRESP;
   logic [2:0]  fsm_state;

   assign HREADY = HREADYOUT;

   ahb_lite_sram_slave #(
      .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .WAIT_CYCLES(WAIT_N)
   ) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .fsm_state(fsm_state)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        write;
      logic [2:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        resp;
      logic [31:0] rdata;
   } vec_t;

   typedef struct packed {
      logic        resp;
      logic [3:0]  waits;
      logic [31:0] rdata;
   } exp_t;

   vec_t vec[64];
   int   nv = 0;
   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;

   localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;

   task automatic add(input logic sel, input logic [1:0] trans, input logic write,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic resp, input logic [31:0] rdata);
      vec[nv].sel   = sel;
      vec[nv].trans = trans;
      vec[nv].write = write;
      vec[nv].size  = size;
      vec[nv].addr  = addr;
      vec[nv].wdata = wdata;
      vec[nv].resp  = resp;
      vec[nv].rdata = rdata;
      nv++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      HSEL = 1'b0; HTRANS = T_IDLE; HWRITE = 1'b0; HSIZE = 3'd0; HADDR = 32'h0;
   endtask

   // Pipelined master: address of vec[a] overlaps the data phase of vec[d].
   task automatic run_vecs(input int lo, input int hi);
      int   a, d, waits, budget;
      bit   busy_d, hrdy;
      exp_t e;
      a = lo; d = lo; busy_d = 0; waits = 0;
      budget = (hi - lo) * 24 + 8;
      while (budget > 0) begin
         budget--;
         if (a < hi) begin
            HSEL = vec[a].sel; HTRANS = vec[a].trans; HWRITE = vec[a].write;
            HSIZE = vec[a].size; HADDR = vec[a].addr;
         end else begin
            drive_idle();
         end
         HWDATA = busy_d ? vec[d].wdata : 32'h0;
         @(negedge HCLK);
         hrdy = HREADYOUT;
         if (busy_d) begin
            if (exp_q.size() == 0) begin
               check($sformatf("v%0d scoreboard_empty", d), 32'd0, 32'd1);
               busy_d = 0;
            end else if (HREADYOUT) begin
               e = exp_q.pop_front();
               check($sformatf("v%0d hresp", d), {31'd0, HRESP}, {31'd0, e.resp});
               check($sformatf("v%0d wait_cycles", d), waits, {28'd0, e.waits});
               check($sformatf("v%0d hrdata", d), HRDATA, e.rdata);
               busy_d = 0;
            end else begin
               waits++;
               check($sformatf("v%0d hresp_stalled", d), {31'd0, HRESP}, {31'd0, exp_q[0].resp});
            end
         end
         @(posedge HCLK); #1;
         if (hrdy && a < hi) begin
            e.resp  = vec[a].resp;
            e.waits = !(vec[a].sel && vec[a].trans[1]) ? 4'd0 : (vec[a].resp ? 4'd1 : 4'(OK_WAITS));
            e.rdata = vec[a].rdata;
            exp_q.push_back(e);
            d = a; busy_d = 1; waits = 0; a++;
         end else if (!busy_d && a >= hi) begin
            return;
         end
      end
      check($sformatf("run_vecs %0d..%0d timeout", lo, hi), 32'd0, 32'd1);
      exp_q.delete();
      drive_idle();
   endtask

   task automatic reset_mid(input logic wr);
      HSEL = 1'b1; HTRANS = T_NSEQ; HWRITE = wr; HSIZE = 3'd2; HADDR = 32'h10;
      @(posedge HCLK); #1;
      drive_idle();
      HWDATA = 32'hFFFF_FFFF;
      HRESET = 1'b0;
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b1;
      HWDATA = 32'h0;
      @(negedge HCLK);
      check($sformatf("reset_mid%0d hreadyout", wr), {31'd0, HREADYOUT}, 32'd1);
      check($sformatf("reset_mid%0d hresp", wr), {31'd0, HRESP}, 32'd0);
      check($sformatf("reset_mid%0d hrdata", wr), HRDATA, 32'd0);
      @(posedge HCLK); #1;
   endtask

   initial begin
      int s1, s2, s3;
      HRESET = 1'b0; HBURST = 3'b001; HPROT = 4'b0011; HWDATA = 32'h0;
      drive_idle();

      s1 = nv;
      add(1, T_NSEQ, 1, 2, 32'h10, 32'h0101_0101, 0, 32'h0);
      add(1, T_IDLE, 0, 0, 32'h0,  32'h0,         0, 32'h0);
      s2 = nv;
      add(1, T_NSEQ, 0, 2, 32'h10, 32'h0,         0, 32'h0101_0101);
      s3 = nv;
      add(1, T_NSEQ, 1, 2, 32'h04, 32'hDEAD_BEEF, 0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h04, 32'h0,         0, 32'hDEAD_BEEF);
      add(1, T_NSEQ, 1, 2, 32'h04, 32'h1122_3344, 0, 32'h0);
      add(1, T_NSEQ, 1, 0, 32'h07, 32'hAA00_0000, 0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h04, 32'h0,         0, 32'hAA22_3344);
      add(1, T_NSEQ, 1, 1, 32'h06, 32'h5566_0000, 0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h04, 32'h0,         0, 32'h5566_3344);
      add(1, T_NSEQ, 1, 2, 32'h08, 32'hCAFE_F00D, 0, 32'h0);
      add(1, T_NSEQ, 1, 0, 32'h0A, 32'h0099_0000, 0, 32'h0);
      add(1, T_NSEQ, 1, 1, 32'h08, 32'h0000_1234, 0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h08, 32'h0,         0, 32'hCA99_1234);
      add(1, T_NSEQ, 0, 2, 32'h02, 32'h0,         1, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h1000, 32'h0,       1, 32'h0);
      add(1, T_NSEQ, 1, 1, 32'h05, 32'hFFFF_FFFF, 1, 32'h0);
      add(1, T_NSEQ, 1, 3, 32'h04, 32'hFFFF_FFFF, 1, 32'h0);
      add(1, T_NSEQ, 1, 0, 32'h1003, 32'hFFFF_FFFF, 1, 32'h0);
      add(0, T_NSEQ, 1, 2, 32'h04, 32'hFFFF_FFFF, 0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h04, 32'h0,         0, 32'h5566_3344);
      add(1, T_NSEQ, 0, 2, 32'h08, 32'h0,         0, 32'hCA99_1234);
      add(1, T_NSEQ, 1, 2, 32'hFFC, 32'h0BAD_CAFE, 0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'hFFC, 32'h0,        0, 32'h0BAD_CAFE);
      add(1, T_NSEQ, 1, 2, 32'h20, 32'h2020_2020, 0, 32'h0);
      add(1, T_IDLE, 0, 0, 32'h0,  32'h0,         0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h20, 32'h0,         0, 32'h2020_2020);
      add(1, T_NSEQ, 1, 2, 32'h40, 32'hA000_0040, 0, 32'h0);
      add(1, T_SEQ,  1, 2, 32'h44, 32'hA000_0044, 0, 32'h0);
      add(1, T_BUSY, 1, 2, 32'h48, 32'h0,         0, 32'h0);
      add(1, T_SEQ,  1, 2, 32'h48, 32'hA000_0048, 0, 32'h0);
      add(1, T_SEQ,  1, 2, 32'h4C, 32'hA000_004C, 0, 32'h0);
      add(1, T_NSEQ, 0, 2, 32'h40, 32'h0,         0, 32'hA000_0040);
      add(1, T_SEQ,  0, 2, 32'h44, 32'h0,         0, 32'hA000_0044);
      add(1, T_SEQ,  0, 2, 32'h48, 32'h0,         0, 32'hA000_0048);
      add(1, T_SEQ,  0, 2, 32'h4C, 32'h0,         0, 32'hA000_004C);
      add(1, T_IDLE, 0, 0, 32'h0,  32'h0,         0, 32'h0);

      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b1;
      @(negedge HCLK);
      check("por hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check("por hresp", {31'd0, HRESP}, 32'd0);
      check("por hrdata", HRDATA, 32'd0);
      check("por fsm_state", {29'd0, fsm_state}, 32'd0);
      @(posedge HCLK); #1;

      run_vecs(s1, s2);
      reset_mid(1'b1);
      run_vecs(s2, s3);
      reset_mid(1'b0);
      run_vecs(s3, nv);
      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #300000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
